alu_iterative: RTL and testbench

- Execute-stage ALU of the pipelined MIPS core, directly downstream of the ALU control decoder; consumes its 3-bit ALU control code.
- ADD, SUB, AND and OR are single-cycle combinational.
- MUL runs on an iterative shift-add multiplier over WIDTH cycles, and asserts stall_o so the hazard unit freezes the pipeline until the product is ready.

---
 rtl/alu_iterative.sv | 121 ++++++++++++
 tb/tb_alu_iterative.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/alu_iterative.sv
// Execute-stage ALU: single-cycle ADD/SUB/AND/OR, iterative shift-add MUL
// that holds stall_o high until the product is ready.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   S_IDLE | combinational ops; a valid MUL raises stall_o and latches operands
//   S_RUN  | one shift-add iteration per cycle, WIDTH cycles total
//   S_DONE | product on data_o, stall_o low; always returns to S_IDLE
module alu_iterative #(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             valid_i,
   input  logic [WIDTH-1:0] data1_i,
   input  logic [WIDTH-1:0] data2_i,
   input  logic [2:0]       ALUCtrl_i,
   output logic [WIDTH-1:0] data_o,
   output logic             zero_o,
   output logic             stall_o
);

   localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_MUL = 3'b101;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;

   logic mul_issue;
   assign mul_issue = valid_i && (ALUCtrl_i == OP_MUL);

   // State and datapath registers, synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
      end
   end

   // Next-state and multiplier iteration.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      unique case (state_q)
         S_IDLE: begin
            if (mul_issue) begin
               mcand_d  = data1_i;
               mplier_d = data2_i;
               acc_d    = '0;
               cnt_d    = '0;
               state_d  = S_RUN;
            end
         end
         S_RUN: begin
            if (mplier_q[0]) acc_d = acc_q + mcand_q;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == CNT_LAST) state_d = S_DONE;
         end
         S_DONE: begin
            // The pipeline advances on this edge; the MUL code still on
            // ALUCtrl_i belongs to the finished instruction, so never re-issue.
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Result, zero flag and stall; reset forces a quiet, non-stalling output.
   always_comb begin
      data_o  = '0;
      stall_o = 1'b0;
      if (!rst_i) begin
         unique case (state_q)
            S_IDLE: begin
               stall_o = mul_issue;
               case (ALUCtrl_i)
                  OP_ADD:  data_o = data1_i + data2_i;
                  OP_SUB:  data_o = data1_i - data2_i;
                  OP_AND:  data_o = data1_i & data2_i;
                  OP_OR:   data_o = data1_i | data2_i;
                  default: data_o = '0;
               endcase
            end
            S_RUN:   stall_o = 1'b1;
            S_DONE:  data_o  = acc_q;
            default: data_o  = '0;
         endcase
      end
      zero_o = (data_o == '0);
   end

endmodule

// File: tb/tb_alu_iterative.sv
// Directed bench for alu_iterative: combinational ops, MUL latency,
// back-to-back MUL, reset mid-MUL and bubble handling.
module tb_alu_iterative;

   localparam int WIDTH = 32;

   logic             clk_i = 1'b0;
   logic             rst_i;
   logic             valid_i;
   logic [WIDTH-1:0] data1_i;
   logic [WIDTH-1:0] data2_i;
   logic [2:0]       ALUCtrl_i;
   logic [WIDTH-1:0] data_o;
   logic             zero_o;
   logic             stall_o;

   int n_checks = 0;
   int n_fail   = 0;
   int n_stall;

   alu_iterative #(.WIDTH(WIDTH)) dut (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .valid_i   (valid_i),
      .data1_i   (data1_i),
      .data2_i   (data2_i),
      .ALUCtrl_i (ALUCtrl_i),
      .data_o    (data_o),
      .zero_o    (zero_o),
      .stall_o   (stall_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Counts cycles with stall_o high starting at the current cycle; stops on
   // the first non-stalling cycle or after a bounded number of cycles.
   task automatic count_stall(output int n);
      n = 0;
      while (stall_o === 1'b1 && n < 40) begin
         n++;
         step();
      end
   endtask

   task automatic drive(input logic v, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b);
      valid_i   = v;
      ALUCtrl_i = op;
      data1_i   = a;
      data2_i   = b;
      #1;
   endtask

   initial begin
      rst_i = 1'b1;
      drive(1'b1, 3'b000, 32'h5, 32'h7);
      chk("rst_data",  data_o,  32'h0);
      chk("rst_zero",  zero_o,  32'h1);
      chk("rst_stall", stall_o, 32'h0);
      step();
      step();
      rst_i = 1'b0;

      // ADD / SUB
      drive(1'b1, 3'b000, 32'h5, 32'h7);
      chk("add_data",  data_o,  32'h0000000C);
      chk("add_zero",  zero_o,  32'h0);
      chk("add_stall", stall_o, 32'h0);
      drive(1'b1, 3'b001, 32'h5, 32'h7);
      chk("sub_data",  data_o,  32'hFFFFFFFE);
      drive(1'b1, 3'b001, 32'h1234, 32'h1234);
      chk("sub0_data", data_o,  32'h0);
      chk("sub0_zero", zero_o,  32'h1);
      chk("sub0_stall", stall_o, 32'h0);

      // AND / OR / unrecognised
      drive(1'b1, 3'b010, 32'hF0F0F0F0, 32'hFF00FF00);
      chk("and_data", data_o, 32'hF000F000);
      drive(1'b1, 3'b011, 32'hF0F0F0F0, 32'hFF00FF00);
      chk("or_data",  data_o, 32'hFFF0FFF0);
      chk("or_zero",  zero_o, 32'h0);
      drive(1'b1, 3'b110, 32'hF0F0F0F0, 32'hFF00FF00);
      chk("inv_data", data_o, 32'h0);
      chk("inv_zero", zero_o, 32'h1);
      step();

      // MUL latency: 3 * 0xFFFFFFFF
      drive(1'b1, 3'b101, 32'h3, 32'hFFFFFFFF);
      chk("mul_issue_stall", stall_o, 32'h1);
      chk("mul_issue_data",  data_o,  32'h0);
      count_stall(n_stall);
      chk("mul_stall_len", n_stall, 32'd33);
      chk("mul_result", data_o, 32'hFFFFFFFD);
      chk("mul_done_stall", stall_o, 32'h0);
      chk("mul_done_zero", zero_o, 32'h0);
      step();
      drive(1'b1, 3'b000, 32'h10, 32'h20);
      chk("mul_after_stall", stall_o, 32'h0);
      chk("mul_after_data",  data_o,  32'h30);
      step();

      // Back-to-back MUL: 7*6 then 0x10000*0x10000
      drive(1'b1, 3'b101, 32'h7, 32'h6);
      chk("b2b1_issue", stall_o, 32'h1);
      count_stall(n_stall);
      chk("b2b1_stall_len", n_stall, 32'd33);
      chk("b2b1_result", data_o, 32'h0000002A);
      chk("b2b1_done_stall", stall_o, 32'h0);
      drive(1'b1, 3'b101, 32'h10000, 32'h10000);
      step();
      chk("b2b2_issue", stall_o, 32'h1);
      count_stall(n_stall);
      chk("b2b2_stall_len", n_stall, 32'd33);
      chk("b2b2_result", data_o, 32'h0);
      chk("b2b2_zero", zero_o, 32'h1);
      chk("b2b2_done_stall", stall_o, 32'h0);
      step();
      drive(1'b0, 3'b000, 32'h0, 32'h0);
      step();

      // Reset during RUN cycle 10
      drive(1'b1, 3'b101, 32'h12345, 32'h777);
      chk("rstm_issue", stall_o, 32'h1);
      for (int i = 0; i < 10; i++) step();
      chk("rstm_run_stall", stall_o, 32'h1);
      chk("rstm_run_zero",  zero_o,  32'h1);
      rst_i = 1'b1;
      #1;
      chk("rstm_stall", stall_o, 32'h0);
      chk("rstm_data",  data_o,  32'h0);
      step();
      rst_i = 1'b0;
      drive(1'b1, 3'b000, 32'h1, 32'h1);
      chk("rstm_add_stall", stall_o, 32'h0);
      chk("rstm_add_data",  data_o,  32'h2);
      step();
      chk("rstm_idle_stall", stall_o, 32'h0);
      chk("rstm_idle_data",  data_o,  32'h2);

      // Bubble with MUL code
      drive(1'b0, 3'b101, 32'h3, 32'h4);
      chk("bub_stall", stall_o, 32'h0);
      chk("bub_data",  data_o,  32'h0);
      chk("bub_zero",  zero_o,  32'h1);
      step();
      drive(1'b0, 3'b000, 32'h3, 32'h4);
      chk("bub_idle_stall", stall_o, 32'h0);
      chk("bub_idle_data",  data_o,  32'h7);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
